// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz) and sync polarity, used by the
// timing generator and by the pixel generators that consume its counters.
package vga_timing_pkg;

    localparam int H_DISP  = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

    localparam int V_DISP  = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    // Both syncs are active-low for this mode.
    localparam logic SYNC_ACTIVE = 1'b0;

    function automatic logic in_window(input logic [9:0] x,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// Free-running divider: en_out pulses for one clk every CLK_DIV clks, on the
// clk in which the count sits at CLK_DIV-1.
module clk_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic en_out
);

    localparam int           W    = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign en_out = (cnt_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters plus sync, valid and start pulses,
// all registered from the decoded next count on each pixel-enable edge.
module vga_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_DISP  = vga_timing_pkg::H_DISP,
    parameter int H_FP    = vga_timing_pkg::H_FP,
    parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int H_BP    = vga_timing_pkg::H_BP,
    parameter int V_DISP  = vga_timing_pkg::V_DISP,
    parameter int V_FP    = vga_timing_pkg::V_FP,
    parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int V_BP    = vga_timing_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       valid,
    output logic       line_start,
    output logic       frame_start
);

    import vga_timing_pkg::*;

    localparam int         H_TOT    = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int         V_TOT    = V_DISP + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISP);
    localparam logic [9:0] V_VIS    = 10'(V_DISP);
    localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC);

    logic       pix_en_w;
    logic [9:0] h_nxt, v_nxt;
    logic [9:0] h_q, h_d, v_q, v_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d, valid_q, valid_d;
    logic       line_start_q, line_start_d, frame_start_q, frame_start_d;

    clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_out (pix_en_w)
    );

    always_comb begin
        h_nxt = h_q + 10'd1;
        v_nxt = v_q;
        if (h_q == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    // Everything decodes the count being loaded, so outputs describe h_cnt/v_cnt
    // as they appear after the edge; the start pulses self-clear a clk later.
    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        valid_d       = valid_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_en_w) begin
            h_d           = h_nxt;
            v_d           = v_nxt;
            hsync_d       = in_window(h_nxt, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_d       = in_window(v_nxt, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            valid_d       = (h_nxt < H_VIS) && (v_nxt < V_VIS);
            line_start_d  = (h_nxt == '0);
            frame_start_d = (h_nxt == '0) && (v_nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            valid_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            valid_q       <= valid_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_en      = pix_en_w;
    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign valid       = valid_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
